// File: rtl/ssd_mux_driver.sv
// Multiplexed N-digit seven-segment driver (common anode, active-low drives) with
// double-buffered frame-boundary reloads and PWM dimming; SSD_LZB_EN adds leading-zero blanking.
module ssd_mux_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_CYC   = 100000,
  parameter int BLANK_CYC  = 2,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BRIGHT_W-1:0]     pwm_q;
  logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d, sh_en_q, sh_en_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    bnd_q, fd_q;
  logic                    slot_wrap, boundary, lit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   blank;

  assign slot_wrap = (slot_q == SLOT_LAST);
  assign boundary  = slot_wrap && (idx_q == IDX_LAST);

  always_comb begin
    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // A load coinciding with the boundary bypasses staging so it is never a frame late.
  always_comb begin
    stg_dig_d = stg_dig_q;
    stg_dp_d  = stg_dp_q;
    stg_en_d  = stg_en_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    pend_d    = pend_q;
    if (load && boundary) begin
      sh_dig_d = digits;
      sh_dp_d  = dp;
      sh_en_d  = digit_en;
      pend_d   = 1'b0;
    end else begin
      if (boundary && pend_q) begin
        sh_dig_d = stg_dig_q;
        sh_dp_d  = stg_dp_q;
        sh_en_d  = stg_en_q;
        pend_d   = 1'b0;
      end
      if (load) begin
        stg_dig_d = digits;
        stg_dp_d  = dp;
        stg_en_d  = digit_en;
        pend_d    = 1'b1;
      end
    end
  end

`ifdef SSD_LZB_EN
  // Scan from the top: zeros are blanked until the first enabled nonzero digit.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (sh_en_q[k] && (sh_dig_q[4*k +: 4] != 4'h0)) seen = 1'b1;
      if ((k != 0) && !seen && sh_en_q[k] && (sh_dig_q[4*k +: 4] == 4'h0)) blank[k] = 1'b1;
    end
  end
`else
  assign blank = '0;
`endif

  assign nib = sh_dig_q[{idx_q, 2'b00} +: 4];
  assign lit = (int'(slot_q) >= BLANK_CYC) && (pwm_q <= brightness) &&
               sh_en_q[idx_q] && !blank[idx_q];

  always_comb begin
    an_n_d  = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_n_d = lit ? dec7(nib) : 7'h7F;
    dp_n_d  = lit ? ~sh_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q    <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      stg_dig_q <= '0;
      stg_dp_q  <= '0;
      stg_en_q  <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      pend_q    <= 1'b0;
      an_n_q    <= '1;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      bnd_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_q + 1'b1;
      stg_dig_q <= stg_dig_d;
      stg_dp_q  <= stg_dp_d;
      stg_en_q  <= stg_en_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      pend_q    <= pend_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      // Two stages so the pulse lines up with the first output cycle of index 0.
      bnd_q     <= boundary;
      fd_q      <= bnd_q;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver: vector table of hex patterns plus reset,
// double-buffer, boundary-load and PWM duty sequences.
module tb_ssd_mux_driver;

  typedef struct packed {
    logic [31:0]     dig;
    logic [7:0]      dp;
    logic [7:0]      en;
    logic [7:0]      lit;
    logic [7:0][6:0] seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] digits;
  logic [7:0]  dp, en;
  logic [3:0]  bright_a, bright_b;
  logic        load;
  logic [6:0]  seg_a, seg_b;
  logic        dpn_a, dpn_b, fd_a, fd_b;
  logic [7:0]  an_a, an_b;

  int   n_chk = 0;
  int   n_pass = 0;
  int   ones_seen = 0;
  logic mon_on = 1'b0;
  vec_t vecs [6];
  vec_t tmp;

  always #5 clk = ~clk;

  ssd_mux_driver #(.NUM_DIGITS(8), .SLOT_CYC(4), .BLANK_CYC(1), .BRIGHT_W(4)) dut (
    .clk(clk), .resetn(resetn), .digits(digits), .dp(dp), .digit_en(en),
    .brightness(bright_a), .load(load), .seg_n(seg_a), .dp_n(dpn_a),
    .an_n(an_a), .frame_done(fd_a)
  );

  ssd_mux_driver #(.NUM_DIGITS(8), .SLOT_CYC(64), .BLANK_CYC(0), .BRIGHT_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .digits(digits), .dp(dp), .digit_en(en),
    .brightness(bright_b), .load(load), .seg_n(seg_b), .dp_n(dpn_b),
    .an_n(an_b), .frame_done(fd_b)
  );

  always @(negedge clk) if (mon_on && an_a != 8'hFF && seg_a == 7'h79) ones_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    digits = d;
    dp     = p;
    en     = e;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_fd_a();
    for (int k = 0; k < 100; k++) begin
      tick();
      if (fd_a) break;
    end
    check("frame_done_a_arrives", 32'(fd_a), 32'd1);
  endtask

  task automatic wait_fd_b();
    for (int k = 0; k < 1200; k++) begin
      tick();
      if (fd_b) break;
    end
    check("frame_done_b_arrives", 32'(fd_b), 32'd1);
  endtask

  // Entered on the frame_done cycle; output cycle c shows index c/4, slot c%4.
  task automatic capture_a(input vec_t v, input string tag);
    int         idx, slot;
    logic       lt;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int c = 0; c < 32; c++) begin
      idx   = c / 4;
      slot  = c % 4;
      lt    = (slot >= 1) && v.lit[idx];
      e_an  = lt ? ~(8'(1) << idx) : 8'hFF;
      e_seg = lt ? v.seg[idx] : 7'h7F;
      e_dp  = lt ? ~v.dp[idx] : 1'b1;
      check($sformatf("%s c%0d {an,seg,dp,fd}", tag, c),
            32'({an_a, seg_a, dpn_a, fd_a}), 32'({e_an, e_seg, e_dp, (c == 0)}));
      if (c < 31) tick();
    end
  endtask

  task automatic duty_b(input int exp_cnt, input string tag);
    int cnt [8];
    int bad;
    int idx;
    bad = 0;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int c = 0; c < 512; c++) begin
      idx = c / 64;
      if (an_b != 8'hFF) begin
        if (an_b == ~(8'(1) << idx) && seg_b == 7'h00 && dpn_b) cnt[idx]++;
        else bad++;
      end
      if (c < 511) tick();
    end
    for (int i = 0; i < 8; i++) check($sformatf("%s slot%0d lit cycles", tag, i), 32'(cnt[i]), 32'(exp_cnt));
    check($sformatf("%s wrong anode/segment cycles", tag), 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; digits = '0; dp = '0; en = '0; load = 1'b0;
    bright_a = 4'hF; bright_b = 4'h3;

    vecs[0] = '{dig: 32'h89AB_CDEF, dp: 8'h00, en: 8'hFF, lit: 8'hFF,
                seg: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[1] = '{dig: 32'h0123_4567, dp: 8'hA5, en: 8'hFF, lit: 8'hFF,
                seg: {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[2] = '{dig: 32'h0000_1000, dp: 8'h08, en: 8'h0F, lit: 8'h0F,
                seg: {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40}};
`ifdef SSD_LZB_EN
    vecs[3] = '{dig: 32'h0000_0305, dp: 8'hFF, en: 8'hFF, lit: 8'h07,
                seg: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12}};
    vecs[5] = '{dig: 32'h0000_0000, dp: 8'h00, en: 8'hF0, lit: 8'h00, seg: {8{7'h40}}};
`else
    vecs[3] = '{dig: 32'h0000_0305, dp: 8'hFF, en: 8'hFF, lit: 8'hFF,
                seg: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12}};
    vecs[5] = '{dig: 32'h0000_0000, dp: 8'h00, en: 8'hF0, lit: 8'hF0, seg: {8{7'h40}}};
`endif
    vecs[4] = '{dig: 32'h7654_3210, dp: 8'h01, en: 8'h01, lit: 8'h01,
                seg: {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};

    repeat (3) tick();
    check("reset {an,seg,dp,fd}", 32'({an_a, seg_a, dpn_a, fd_a}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
    resetn = 1'b1;
    tmp = '0;
    wait_fd_a();
    capture_a(tmp, "post_reset_dark");

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].dig, vecs[i].dp, vecs[i].en);
      wait_fd_a();
      wait_fd_a();
      capture_a(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of a lit slot.
    do_load(vecs[0].dig, vecs[0].dp, vecs[0].en);
    wait_fd_a();
    wait_fd_a();
    repeat (5) tick();
    check("pre_reset an", 32'(an_a), 32'h0000_00FD);
    resetn = 1'b0;
    #1;
    check("async_reset {an,seg,dp,fd}", 32'({an_a, seg_a, dpn_a, fd_a}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
    tick();
    check("reset_next {an,seg,dp,fd}", 32'({an_a, seg_a, dpn_a, fd_a}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
    resetn = 1'b1;
    wait_fd_a();
    capture_a(tmp, "midreset_dark");

    // Second load two cycles after the first, both mid-frame.
    mon_on = 1'b1;
    wait_fd_a();
    repeat (5) tick();
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    tick();
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    wait_fd_a();
    tmp = '{dig: 32'h2222_2222, dp: 8'h00, en: 8'hFF, lit: 8'hFF, seg: {8{7'h24}}};
    capture_a(tmp, "dbuf_twos");
    mon_on = 1'b0;
    check("dbuf ones ever shown", 32'(ones_seen), 32'd0);

    // Load landing exactly on the boundary cycle (30 cycles after frame_done).
    wait_fd_a();
    repeat (30) tick();
    do_load(32'h3333_3333, 8'h00, 8'hFF);
    tmp = '{dig: 32'h3333_3333, dp: 8'h00, en: 8'hFF, lit: 8'hFF, seg: {8{7'h30}}};
    wait_fd_a();
    capture_a(tmp, "bnd_load");
    wait_fd_a();
    capture_a(tmp, "bnd_load_hold");

    // PWM duty on the 64-cycle-slot instance.
    do_load(32'h8888_8888, 8'h00, 8'hFF);
    wait_fd_b();
    wait_fd_b();
    duty_b(16, "bright3");
    bright_b = 4'h0;
    wait_fd_b();
    duty_b(4, "bright0");
    bright_b = 4'hF;
    wait_fd_b();
    duty_b(64, "brightF");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
